// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/acknowledge bus between fetch and imem.
interface fetch_unit_if #(parameter int ADDR_W = 16);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [15:0]       rdata;
    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and single-outstanding instruction fetch over a req/ack bus.
// Define ALIGN_CHECK_EN to flag odd branch/jump targets on o_misalign_err.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [15:0]       o_inst,
    output logic [3:0]        o_opcode,
    output logic [ADDR_W-1:0] o_pc_out,
    output logic [ADDR_W-1:0] o_pc_plus2,
    input  logic [1:0]        i_pcsrc,
    input  logic [ADDR_W-1:0] i_imm_sext,
    input  logic [ADDR_W-1:0] i_reg_off,
    output logic [15:0]       o_retire_cnt,
    output logic              o_misalign_err
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_inst;
    logic [15:0]       r_cnt;
    logic              r_req;
    logic              r_valid;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_next;
    logic              w_accept;
    // pcsrc 3 is reserved and falls back to sequential fetch
    assign w_off    = i_pcsrc == 2'd1 ? i_imm_sext : i_pcsrc == 2'd2 ? i_reg_off : ADDR_W'(2);
    assign w_next   = r_pc + w_off;
    assign w_accept = r_valid & i_inst_ready;
    assign imem.req     = r_req;
    assign imem.addr    = r_pc;
    assign o_inst_valid = r_valid;
    assign o_inst       = r_inst;
    assign o_opcode     = r_inst[15:12];
    assign o_pc_out     = r_pc;
    assign o_pc_plus2   = r_pc + ADDR_W'(2);
    assign o_retire_cnt = r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: if (imem.ack) begin
                    r_inst  <= imem.rdata;
                    r_req   <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_VALID;
                end
                S_VALID: if (i_inst_ready) begin
                    r_pc    <= {w_next[ADDR_W-1:1], 1'b0};
                    r_cnt   <= r_cnt + 16'd1;
                    r_valid <= 1'b0;
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end
`ifdef ALIGN_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else if (w_accept && w_next[0]) r_err <= 1'b1;
    end
    assign o_misalign_err = r_err;
`else
    assign o_misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit; expected values are hand-computed.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, inst_ready;
    logic [15:0] inst, pc_out, pc_plus2, imm_sext, reg_off, retire_cnt;
    logic [3:0]  opcode;
    logic [1:0]  pcsrc;
    logic        misalign_err;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = 16'd0;
`ifdef ALIGN_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    fetch_unit_if bus();

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem(bus),
        .o_inst_valid(inst_valid), .i_inst_ready(inst_ready), .o_inst(inst),
        .o_opcode(opcode), .o_pc_out(pc_out), .o_pc_plus2(pc_plus2),
        .i_pcsrc(pcsrc), .i_imm_sext(imm_sext), .i_reg_off(reg_off),
        .o_retire_cnt(retire_cnt), .o_misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] word);
        logic [15:0] p2;
        logic [3:0]  op;
        p2 = exp_addr + 16'd2;
        op = word[15:12];
        chk("fetch_req", bus.req, 1);
        chk("fetch_addr", bus.addr, exp_addr);
        bus.ack = 1'b1;
        bus.rdata = word;
        step;
        bus.ack = 1'b0;
        chk("valid", inst_valid, 1);
        chk("req_low", bus.req, 0);
        chk("inst", inst, word);
        chk("opcode", opcode, op);
        chk("pc_out", pc_out, exp_addr);
        chk("pc_plus2", pc_plus2, p2);
    endtask

    task automatic accept(input logic [1:0] src, input logic [15:0] imm, input logic [15:0] off,
                          input logic [15:0] exp_next);
        inst_ready = 1'b1;
        pcsrc = src;
        imm_sext = imm;
        reg_off = off;
        step;
        inst_ready = 1'b0;
        pcsrc = 2'd1;
        imm_sext = 16'h4444;
        reg_off = 16'h6666;
        exp_cnt = exp_cnt + 16'd1;
        chk("acc_valid", inst_valid, 0);
        chk("acc_req", bus.req, 1);
        chk("acc_addr", bus.addr, exp_next);
        chk("retire_cnt", retire_cnt, exp_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        inst_ready = 1'b0;
        pcsrc = 2'd0;
        imm_sext = 16'd0;
        reg_off = 16'd0;
        bus.ack = 1'b0;
        bus.rdata = 16'd0;
        step;
        step;
        chk("rst_req", bus.req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_cnt", retire_cnt, 16'h0000);
        chk("rst_mis", misalign_err, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("idle_req", bus.req, 0);
        step;
        fetch(16'h0000, 16'h8123);
        accept(2'd0, 16'h0, 16'h0, 16'h0002);
        fetch(16'h0002, 16'h8123);
        accept(2'd0, 16'h0, 16'h0, 16'h0004);
        fetch(16'h0004, 16'h8123);
        // ack arriving while an instruction is held must not overwrite it
        bus.ack = 1'b1;
        bus.rdata = 16'h1234;
        step;
        bus.ack = 1'b0;
        chk("ack_ign_inst", inst, 16'h8123);
        chk("ack_ign_valid", inst_valid, 1);
        accept(2'd1, 16'h000C, 16'h0, 16'h0010);
        fetch(16'h0010, 16'hA001);
        accept(2'd1, 16'hFFF0, 16'h0, 16'h0000);
        fetch(16'h0000, 16'h5555);
        accept(2'd1, 16'h0020, 16'h0, 16'h0020);
        fetch(16'h0020, 16'hB002);
        chk("mis_before", misalign_err, 0);
        accept(2'd2, 16'h0, 16'h0105, 16'h0124);
        chk("mis_after", misalign_err, EXP_MIS);
        repeat (5) begin
            step;
            chk("stall_req", bus.req, 1);
            chk("stall_addr", bus.addr, 16'h0124);
        end
        fetch(16'h0124, 16'hC0DE);
        repeat (4) begin
            step;
            chk("hold_valid", inst_valid, 1);
            chk("hold_inst", inst, 16'hC0DE);
        end
        accept(2'd3, 16'h1000, 16'h2000, 16'h0126);
        fetch(16'h0126, 16'h3141);
        accept(2'd1, 16'hFED8, 16'h0, 16'hFFFE);
        fetch(16'hFFFE, 16'h7777);
        accept(2'd0, 16'h0, 16'h0, 16'h0000);
        chk("mis_sticky", misalign_err, EXP_MIS);
        rst_n = 1'b0;
        #1;
        chk("rf_req", bus.req, 0);
        chk("rf_pc", pc_out, 16'h0000);
        chk("rf_cnt", retire_cnt, 16'h0000);
        chk("rf_mis", misalign_err, 0);
        step;
        @(negedge clk) rst_n = 1'b1;
        exp_cnt = 16'd0;
        #1 chk("rf_idle_req", bus.req, 0);
        step;
        fetch(16'h0000, 16'h9999);
        bus.ack = 1'b1;
        bus.rdata = 16'hDEAD;
        rst_n = 1'b0;
        #1;
        chk("rv_valid", inst_valid, 0);
        chk("rv_inst", inst, 16'h0000);
        chk("rv_req", bus.req, 0);
        step;
        bus.ack = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step;
        chk("rv_restart_req", bus.req, 1);
        chk("rv_restart_valid", inst_valid, 0);
        chk("rv_restart_addr", bus.addr, 16'h0000);
        fetch(16'h0000, 16'h4242);
        accept(2'd0, 16'h0, 16'h0, 16'h0002);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
